// File: rtl/fsmc_pkg.sv
// Shared types and constants for the FSMC front end and the sdma back end.
package fsmc_pkg;

  localparam int unsigned FSMC_ADDR_W = 18;
  localparam int unsigned FSMC_DATA_W = 16;

  // sdma status register and per-buffer depth
  localparam logic [17:0] STATE_ADDR = 18'h04000;
  localparam int unsigned BUF_SIZE   = 1024;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWdata,
    StRwait,
    StRdrive
  } fsmc_state_t;

endpackage

// File: rtl/fsmc_bus_slave_if.sv
// FSMC strobes plus the write-pulse / read request-valid handshake to the back end.
interface fsmc_bus_slave_if
  import fsmc_pkg::*;
#(
  parameter int unsigned ADDR_W = FSMC_ADDR_W,
  parameter int unsigned DATA_W = FSMC_DATA_W
);

  logic              nadv;
  logic              nwe;
  logic              noe;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport slave (
    input  nadv, nwe, noe, rd_data, rd_valid,
    output wr_en, wr_addr, wr_data, rd_req, rd_addr
  );

  modport master (
    output nadv, nwe, noe, rd_data, rd_valid,
    input  wr_en, wr_addr, wr_data, rd_req, rd_addr
  );

endinterface

// File: rtl/sync_bit.sv
// Single-bit synchroniser chain; reset value chosen so strobes come up inactive.
module sync_bit #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {Stages{ResetVal}};
    end else begin
      chain_q[0] <= d_i;
      for (int i = 1; i < Stages; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
    end
  end

  assign q_o = chain_q[Stages-1];

endmodule

// File: rtl/fsmc_bus_slave.sv
// FSMC multiplexed-bus slave: synchronises strobes, latches address, and turns
// bus cycles into back-end write pulses and read request/valid handshakes.
module fsmc_bus_slave
  import fsmc_pkg::*;
#(
  parameter int unsigned ADDR_W      = FSMC_ADDR_W,
  parameter int unsigned DATA_W      = FSMC_DATA_W,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RD_TIMEOUT  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inout  wire  [ADDR_W-1:0]    ad_io,
  fsmc_bus_slave_if.slave      bus,
  output logic                 bus_err_o,
  output logic                 busy_o
);

  localparam int unsigned CntW = $clog2(RD_TIMEOUT + 1);

  logic nadv_s, nwe_s, noe_s;

  sync_bit #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_nadv (
    .clk(clk), .rst_n(rst_n), .d_i(bus.nadv), .q_o(nadv_s)
  );
  sync_bit #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_nwe (
    .clk(clk), .rst_n(rst_n), .d_i(bus.nwe), .q_o(nwe_s)
  );
  sync_bit #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_noe (
    .clk(clk), .rst_n(rst_n), .d_i(bus.noe), .q_o(noe_s)
  );

  // Same depth as the strobe chains so address/data line up with their strobe.
  logic [ADDR_W-1:0] ad_pipe_q [SYNC_STAGES];
  logic [ADDR_W-1:0] ad_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) ad_pipe_q[i] <= '0;
    end else begin
      ad_pipe_q[0] <= ad_io;
      for (int i = 1; i < SYNC_STAGES; i++) ad_pipe_q[i] <= ad_pipe_q[i-1];
    end
  end

  assign ad_s = ad_pipe_q[SYNC_STAGES-1];

  fsmc_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              drive_q, drive_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              rd_req_q, rd_req_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              bus_err_q, bus_err_d;
  logic              both_low;

  assign both_low = ~nwe_s & ~noe_s;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_req_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    bus_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!nadv_s) begin
          addr_d  = ad_s;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (!nadv_s) begin
          addr_d = ad_s;
        end else if (both_low) begin
          bus_err_d = 1'b1;
          state_d   = StIdle;
        end else if (!nwe_s) begin
          data_d  = ad_s[DATA_W-1:0];
          state_d = StWdata;
        end else if (!noe_s) begin
          rd_req_d  = 1'b1;
          rd_addr_d = addr_q;
          cnt_d     = '0;
          state_d   = StRwait;
        end
      end
      StWdata: begin
        if (both_low) begin
          bus_err_d = 1'b1;
          state_d   = StIdle;
        end else if (!nwe_s) begin
          data_d = ad_s[DATA_W-1:0];
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = data_q;
          state_d   = StIdle;
        end
      end
      StRwait: begin
        // cnt_q is 0 in the rd_req cycle, so the timeout lands RD_TIMEOUT cycles after it
        if (both_low) begin
          bus_err_d = 1'b1;
          state_d   = StIdle;
        end else if (noe_s) begin
          state_d = StIdle;
        end else if (bus.rd_valid) begin
          rdata_d = bus.rd_data;
          state_d = StRdrive;
        end else if (cnt_q == CntW'(RD_TIMEOUT - 1)) begin
          rdata_d   = '0;
          bus_err_d = 1'b1;
          state_d   = StRdrive;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRdrive: begin
        if (noe_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    drive_d = (state_d == StRdrive);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      data_q    <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      drive_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      drive_q   <= drive_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Raw NOE/NADV so the bus is released the instant the MCU ends the read.
  logic ad_oe;
  assign ad_oe = drive_q & ~bus.noe & bus.nadv;
  assign ad_io = ad_oe ? {{(ADDR_W - DATA_W){1'b0}}, rdata_q} : 'z;

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.rd_req  = rd_req_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus_err_o   = bus_err_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_fsmc_bus_slave.sv
// Scoreboard bench for fsmc_bus_slave: stimulus queues expected back-end events,
// a negedge monitor pops and compares them as the DUT emits them.
module tb_fsmc_bus_slave;
  import fsmc_pkg::*;

  localparam logic [17:0] HIZ = 18'h3FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #2 clk = ~clk;

  fsmc_bus_slave_if #(.ADDR_W(18), .DATA_W(16)) bus ();

  wire  [17:0] ad;
  logic [17:0] mcu_ad;
  logic        mcu_en;
  logic        bus_err;
  logic        busy;

  assign ad = mcu_en ? mcu_ad : 'z;
  for (genvar i = 0; i < 18; i++) begin : g_pu
    pullup pu (ad[i]);
  end

  fsmc_bus_slave #(
    .ADDR_W(18), .DATA_W(16), .SYNC_STAGES(2), .RD_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ad_io(ad),
    .bus(bus),
    .bus_err_o(bus_err),
    .busy_o(busy)
  );

  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_wr_q[$];
  logic [17:0] exp_rd_q[$];
  int          exp_err_q[$];   // 1 = read timeout, 2 = protocol violation

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdreq_cyc = 0;
  wr_t mon_e;
  logic [17:0] mon_a;
  int mon_k;

  int resp_delay = -1;
  logic [15:0] resp_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [17:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_wr_q.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wr_en) begin
        chk("wr_en_expected", exp_wr_q.size() > 0, 1);
        if (exp_wr_q.size() > 0) begin
          mon_e = exp_wr_q.pop_front();
          chk("wr_addr", bus.wr_addr, mon_e.addr);
          chk("wr_data", bus.wr_data, mon_e.data);
        end
      end
      if (bus.rd_req) begin
        rdreq_cyc = cyc;
        chk("rd_req_expected", exp_rd_q.size() > 0, 1);
        if (exp_rd_q.size() > 0) begin
          mon_a = exp_rd_q.pop_front();
          chk("rd_addr", bus.rd_addr, mon_a);
        end
      end
      if (bus_err) begin
        chk("bus_err_expected", exp_err_q.size() > 0, 1);
        if (exp_err_q.size() > 0) begin
          mon_k = exp_err_q.pop_front();
          if (mon_k == 1) chk("timeout_latency", cyc - rdreq_cyc, 8);
        end
      end
    end
  end

  // Back-end read responder
  initial begin
    bus.rd_valid = 1'b0;
    bus.rd_data  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rd_req && resp_delay >= 0) begin
        repeat (resp_delay) @(posedge clk);
        #1;
        bus.rd_valid = 1'b1;
        bus.rd_data  = resp_data;
        @(posedge clk);
        #1;
        bus.rd_valid = 1'b0;
      end
    end
  end

  task automatic addr_phase(input logic [17:0] a);
    @(posedge clk);
    #1;
    mcu_ad   = a;
    mcu_en   = 1'b1;
    bus.nadv = 1'b0;
    #5;
    bus.nadv = 1'b1;
    #1;
    mcu_en = 1'b0;
  endtask

  task automatic mcu_write(input logic [17:0] a, input logic [15:0] d);
    addr_phase(a);
    mcu_ad  = {2'b00, d};
    mcu_en  = 1'b1;
    bus.nwe = 1'b0;
    #10;
    bus.nwe = 1'b1;
    #1;
    mcu_en = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic wait_rdreq();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rd_req && n < 40);
    chk("rd_req_seen", bus.rd_req, 1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  initial begin
    bus.nadv = 1'b1;
    bus.nwe  = 1'b1;
    bus.noe  = 1'b1;
    mcu_ad   = '0;
    mcu_en   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_rd_req", bus.rd_req, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ad_hiz", ad, HIZ);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // 1: plain write to the status register
    push_wr(STATE_ADDR, 16'h0001);
    mcu_write(STATE_ADDR, 16'h0001);
    #1;
    chk("t1_ad_hiz", ad, HIZ);
    chk("t1_busy", busy, 0);
    chk("t1_wr_addr_hold", bus.wr_addr, STATE_ADDR);

    // 2: read with back end answering 2 cycles after rd_req
    resp_delay = 2;
    resp_data  = 16'h0ABC;
    exp_rd_q.push_back(18'h00005);
    addr_phase(18'h00005);
    bus.noe = 1'b0;
    wait_rdreq();
    repeat (6) @(posedge clk);
    #1;
    chk("t2_ad_drive", ad, 18'h00ABC);
    bus.noe = 1'b1;
    #1;
    chk("t2_ad_release", ad, HIZ);
    repeat (6) @(posedge clk);
    #1;
    chk("t2_busy", busy, 0);

    // 3: read timeout
    resp_delay = -1;
    exp_rd_q.push_back(STATE_ADDR);
    exp_err_q.push_back(1);
    addr_phase(STATE_ADDR);
    bus.noe = 1'b0;
    wait_rdreq();
    repeat (10) @(posedge clk);
    #1;
    chk("t3_ad_zero", ad, 18'h00000);
    chk("t3_busy_drive", busy, 1);
    bus.noe = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("t3_idle", busy, 0);

    // 4: MCU abandons read before rd_valid, then a normal read
    resp_delay = 6;
    resp_data  = 16'hDEAD;
    exp_rd_q.push_back(18'h00020);
    addr_phase(18'h00020);
    bus.noe = 1'b0;
    wait_rdreq();
    @(posedge clk);
    #1;
    bus.noe = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t4_ad_hiz", ad, HIZ);
    chk("t4_idle", busy, 0);
    resp_delay = 1;
    resp_data  = 16'h0777;
    exp_rd_q.push_back(18'h00007);
    addr_phase(18'h00007);
    bus.noe = 1'b0;
    wait_rdreq();
    repeat (5) @(posedge clk);
    #1;
    chk("t4_ad_drive", ad, 18'h00777);
    bus.noe = 1'b1;
    repeat (6) @(posedge clk);

    // 5: both strobes low after the address phase
    exp_err_q.push_back(2);
    addr_phase(18'h00100);
    bus.nwe = 1'b0;
    bus.noe = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("t5_ad_hiz", ad, HIZ);
    chk("t5_idle", busy, 0);
    bus.nwe = 1'b1;
    bus.noe = 1'b1;
    repeat (4) @(posedge clk);

    // 6: reset while driving read data, then a write
    resp_delay = 1;
    resp_data  = 16'h5A5A;
    exp_rd_q.push_back(18'(BUF_SIZE - 1));
    addr_phase(18'(BUF_SIZE - 1));
    bus.noe = 1'b0;
    wait_rdreq();
    repeat (5) @(posedge clk);
    #1;
    chk("t6_ad_drive", ad, 18'h05A5A);
    rst_n = 1'b0;
    #1;
    chk("t6_ad_hiz", ad, HIZ);
    chk("t6_wr_en", bus.wr_en, 0);
    chk("t6_rd_req", bus.rd_req, 0);
    chk("t6_bus_err", bus_err, 0);
    chk("t6_busy", busy, 0);
    chk("t6_wr_addr", bus.wr_addr, 0);
    chk("t6_wr_data", bus.wr_data, 0);
    chk("t6_rd_addr", bus.rd_addr, 0);
    bus.noe = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    push_wr(18'h00010, 16'h1234);
    mcu_write(18'h00010, 16'h1234);
    repeat (4) @(posedge clk);

    chk("wr_q_empty", exp_wr_q.size(), 0);
    chk("rd_q_empty", exp_rd_q.size(), 0);
    chk("err_q_empty", exp_err_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
